chi_home_node_q: RTL

//  Queued CHI home node: target-filtered request intake into a FIFO, per-line memory plus ownership table,
//  and a handshake-correct RSP-then-DATA reply for every request. Successor of the single-request home node

---
 rtl/chi_home_node_q.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/chi_home_node_q.sv
// Queued CHI home node: FIFO request intake, line memory with ownership, RSP-then-DATA replies.
// Optional ownership trace via CHI_HN_OWNER_TRACE_EN.
`timescale 1ns/1ps

package chi_pkg;
  typedef enum logic [1:0] {
    FLIT_REQ  = 2'd0,
    FLIT_RSP  = 2'd1,
    FLIT_DATA = 2'd2
  } flit_type_e;

  localparam logic [5:0] OP_READ_SHARED  = 6'h01;
  localparam logic [5:0] OP_WRITE_UNIQUE = 6'h19;
  localparam logic [5:0] OP_WRITE_BACK   = 6'h1B;

  typedef struct packed {
    flit_type_e  flit_type;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  src_id;
    logic [3:0]  tgt_id;
  } chi_flit;
endpackage

module chi_home_node_q
  import chi_pkg::*;
#(
  parameter logic [3:0] MY_NODE_ID = 4'd0,
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flit_valid,
  output logic             flit_ready,
  input  chi_flit          flit_in,
  output logic             flit_valid_out,
  input  logic             flit_ready_out,
  output chi_flit          flit_out,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RSP  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  chi_flit          r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [PTR_W:0]   r_cnt;

  logic [31:0] r_mem [MEM_DEPTH];
  logic [3:0]  r_own [MEM_DEPTH];

  logic [CNT_W-1:0] r_conf;
  logic             r_vld;
  chi_flit          r_out;
  logic [31:0]      r_ddata;

  logic             w_push;
  logic             w_pop;
  chi_flit          w_head;
  logic [IDX_W-1:0] w_idx;
  logic             w_inr;
  logic [3:0]       w_old;
  logic             w_is_rs;
  logic             w_is_wu;
  logic             w_is_wb;
  logic             w_wb_ok;
  logic             w_conf;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign flit_ready = (r_cnt != FULL_CNT);
  assign w_push = flit_valid && flit_ready
                  && (flit_in.tgt_id == MY_NODE_ID);
  assign w_pop  = (r_state == S_IDLE) && (r_cnt != '0);

  assign w_head  = r_fifo[r_rp];
  assign w_idx   = w_head.address[IDX_W+1:2];
  assign w_inr   = (w_head.address[31:2] < 30'(MEM_DEPTH));
  assign w_old   = r_own[w_idx];
  assign w_is_rs = (w_head.opcode == OP_READ_SHARED);
  assign w_is_wu = (w_head.opcode == OP_WRITE_UNIQUE);
  assign w_is_wb = (w_head.opcode == OP_WRITE_BACK);
  assign w_wb_ok = (w_old == 4'd0) || (w_old == w_head.src_id);
  assign w_unused = ^{w_head.flit_type, w_head.tgt_id};

  assign w_conf = w_pop && w_inr && (
    (w_is_wu && w_old != 4'd0 && w_old != w_head.src_id) ||
    (w_is_wb && !w_wb_ok));

  // Reads of out-of-range lines return zero; non-reads echo the request data.
  always_comb begin
    w_rdata = w_head.data;
    if (w_is_rs) w_rdata = w_inr ? r_mem[w_idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= flit_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
        r_own[i] <= '0;
      end
    end else if (w_pop && w_inr) begin
      if (w_is_wu) begin
        r_mem[w_idx] <= w_head.data;
        r_own[w_idx] <= w_head.src_id;
      end else if (w_is_wb && w_wb_ok) begin
        r_mem[w_idx] <= w_head.data;
        r_own[w_idx] <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conf <= '0;
    end else if (w_conf && !(&r_conf)) begin
      r_conf <= r_conf + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (r_cnt != '0)    w_next = S_RSP;
      S_RSP:   if (flit_ready_out) w_next = S_DATA;
      S_DATA:  if (flit_ready_out) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= 1'b0;
      r_out   <= '0;
      r_ddata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_pop) begin
          r_vld   <= 1'b1;
          r_ddata <= w_rdata;
          r_out   <= '{flit_type: FLIT_RSP,
                       txn_id:    w_head.txn_id,
                       opcode:    w_head.opcode,
                       address:   w_head.address,
                       data:      32'h0,
                       src_id:    MY_NODE_ID,
                       tgt_id:    w_head.src_id};
        end
        S_RSP: if (flit_ready_out) begin
          r_out.flit_type <= FLIT_DATA;
          r_out.data      <= r_ddata;
        end
        S_DATA: if (flit_ready_out) begin
          r_vld <= 1'b0;
          r_out <= '0;
        end
        default: r_vld <= 1'b0;
      endcase
    end
  end

`ifdef CHI_HN_OWNER_TRACE_EN
  always @(posedge clk) begin
    if (rst && w_pop && w_inr) begin
      if (w_is_wu && w_old != w_head.src_id)
        $display("[Ownership] Addr=0x%08h Owner=%0d",
                 w_head.address, w_head.src_id);
      if (w_is_wb && w_wb_ok && w_old != 4'd0)
        $display("[Ownership] Addr=0x%08h Owner=%0d",
                 w_head.address, 0);
      if (w_conf)
        $display("[Conflict] Addr=0x%08h Old=%0d New=%0d",
                 w_head.address, w_old, w_head.src_id);
    end
  end
`endif

  assign flit_valid_out = r_vld;
  assign flit_out       = r_out;
  assign busy           = (r_cnt != '0) || (r_state != S_IDLE);
  assign conflict_cnt   = r_conf;

endmodule
